// File: rtl/sram_port_responder.sv
// rtl/sram_port_responder.sv - SRAM-style port responder: kseg translation, range check, word array, counters
module sram_port_responder #(
  parameter int          DEPTH      = 4096,
  parameter logic [31:0] BASE_PADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        addr_err,
  output logic [31:0] err_addr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0] mem [DEPTH];

  logic [31:0] paddr;
  logic        borrow;
  logic [31:0] offset;
  logic [31:0] word_off;
  logic        in_range;
  logic [AW-1:0] idx;
  logic        is_write;
  logic [31:0] cur_word;
  logic [31:0] merged;

  // Address translation and range check; the 33-bit subtract exposes paddr < BASE as a borrow
  always_comb begin
    paddr = sram_addr;
    if (sram_addr[31:30] == 2'b10) begin
      paddr = {3'b000, sram_addr[28:0]};
    end
    {borrow, offset} = {1'b0, paddr} - {1'b0, BASE_PADDR};
    word_off = offset >> 2;
    in_range = !borrow && (word_off < 32'(DEPTH));
    idx      = word_off[AW-1:0];
    is_write = (sram_wen != 4'b0000);
  end

  assign cur_word = mem[idx];

  // Byte-lane merge of the write data into the currently stored word
  always_comb begin
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (sram_wen[i]) begin
        merged[8*i +: 8] = sram_wdata[8*i +: 8];
      end
    end
  end

  // Next-state logic: any request keeps or moves the port in RESP, a quiet cycle drops to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (sram_en) state_next = RESP;
      RESP: if (!sram_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Word array; not reset, and an access seen while rst is high never lands
  always_ff @(posedge clk) begin
    if (!rst && sram_en && in_range && is_write) begin
      mem[idx] <= merged;
    end
  end

  // State, response register, sticky error capture and traffic counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sram_rdata <= 32'h0;
      addr_err   <= 1'b0;
      err_addr   <= 32'h0;
      rd_cnt     <= 32'h0;
      wr_cnt     <= 32'h0;
    end else begin
      state <= state_next;
      if (sram_en) begin
        if (in_range) begin
          if (is_write) begin
            sram_rdata <= merged;
            wr_cnt     <= wr_cnt + 32'd1;
          end else begin
            sram_rdata <= cur_word;
            rd_cnt     <= rd_cnt + 32'd1;
          end
        end else begin
          sram_rdata <= 32'h0;
          addr_err   <= 1'b1;
          if (!addr_err) begin
            err_addr <= paddr;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_port_responder.sv
// tb/tb_sram_port_responder.sv - directed self-checking bench for sram_port_responder
module tb_sram_port_responder;

  logic        clk;
  logic        rst;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        addr_err;
  logic [31:0] err_addr;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int errors = 0;
  int checks = 0;

  sram_port_responder #(
    .DEPTH      (4096),
    .BASE_PADDR (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .addr_err   (addr_err),
    .err_addr   (err_addr),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request, let one rising edge pass, return 1 time unit after it
  task automatic acc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    sram_en    = e;
    sram_wen   = w;
    sram_addr  = a;
    sram_wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    sram_en = 1'b0;
    sram_wen = 4'h0;
    sram_addr = 32'h0;
    sram_wdata = 32'h0;
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_rdata", sram_rdata, 32'h0);
    check("reset_addr_err", {31'h0, addr_err}, 32'h0);
    check("reset_err_addr", err_addr, 32'h0);
    check("reset_rd_cnt", rd_cnt, 32'h0);
    check("reset_wr_cnt", wr_cnt, 32'h0);
    rst = 1'b0;

    // byte lanes through kseg0 write and kseg1 read
    acc(1'b1, 4'hF, 32'h8000_0010, 32'h1122_3344);
    check("lane_full_write_rdata", sram_rdata, 32'h1122_3344);
    acc(1'b1, 4'h5, 32'h8000_0010, 32'hAABB_CCDD);
    check("lane_partial_write_rdata", sram_rdata, 32'h11BB_33DD);
    acc(1'b1, 4'h0, 32'hA000_0010, 32'h0);
    check("lane_read_rdata", sram_rdata, 32'h11BB_33DD);
    check("lane_wr_cnt", wr_cnt, 32'd2);
    check("lane_rd_cnt", rd_cnt, 32'd1);

    // store then load on the very next cycle
    acc(1'b1, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF);
    check("raw_write_rdata", sram_rdata, 32'hDEAD_BEEF);
    acc(1'b1, 4'h0, 32'h0000_0020, 32'h0);
    check("raw_read_rdata", sram_rdata, 32'hDEAD_BEEF);

    // hold while idle
    acc(1'b1, 4'hF, 32'h0000_0024, 32'h1234_5678);
    acc(1'b1, 4'h0, 32'h0000_0024, 32'h0);
    check("hold_read_rdata", sram_rdata, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      acc(1'b0, 4'hF, 32'h0000_0024, 32'hFFFF_FFFF);
      check("hold_idle_rdata", sram_rdata, 32'h1234_5678);
    end
    check("hold_rd_cnt", rd_cnt, 32'd3);
    check("hold_wr_cnt", wr_cnt, 32'd4);

    // top word of the array is in range
    acc(1'b1, 4'hF, 32'h0000_0000, 32'h0F0F_0F0F);
    acc(1'b1, 4'hF, 32'h0000_3FFC, 32'h0BAD_CAFE);
    acc(1'b1, 4'h0, 32'h0000_3FFC, 32'h0);
    check("top_word_rdata", sram_rdata, 32'h0BAD_CAFE);
    check("top_word_addr_err", {31'h0, addr_err}, 32'h0);
    check("top_word_rd_cnt", rd_cnt, 32'd4);

    // first word past the array
    acc(1'b1, 4'h0, 32'h0000_4000, 32'h0);
    check("range_rdata", sram_rdata, 32'h0);
    check("range_addr_err", {31'h0, addr_err}, 32'h1);
    check("range_err_addr", err_addr, 32'h0000_4000);
    check("range_rd_cnt", rd_cnt, 32'd4);
    acc(1'b1, 4'h0, 32'h0000_8000, 32'h0);
    check("range_second_err_addr", err_addr, 32'h0000_4000);

    // out-of-range write must not alias onto word 0
    acc(1'b1, 4'h0, 32'h0000_0024, 32'h0);
    acc(1'b1, 4'hF, 32'h0000_4000, 32'hFFFF_FFFF);
    check("range_write_rdata", sram_rdata, 32'h0);
    check("range_write_wr_cnt", wr_cnt, 32'd6);
    acc(1'b1, 4'h0, 32'h0000_0000, 32'h0);
    check("no_alias_rdata", sram_rdata, 32'h0F0F_0F0F);
    check("no_alias_rd_cnt", rd_cnt, 32'd6);

    // reset arriving during a write
    acc(1'b1, 4'hF, 32'h0000_0030, 32'hCAFE_F00D);
    sram_en    = 1'b1;
    sram_wen   = 4'hF;
    sram_addr  = 32'h0000_0030;
    sram_wdata = 32'h5555_5555;
    #1 rst = 1'b1;
    #1;
    check("async_rst_rdata", sram_rdata, 32'h0);
    check("async_rst_addr_err", {31'h0, addr_err}, 32'h0);
    check("async_rst_err_addr", err_addr, 32'h0);
    check("async_rst_rd_cnt", rd_cnt, 32'h0);
    check("async_rst_wr_cnt", wr_cnt, 32'h0);
    @(posedge clk);
    #1;
    sram_en = 1'b0;
    rst = 1'b0;
    acc(1'b1, 4'h0, 32'h0000_0030, 32'h0);
    check("post_rst_rdata", sram_rdata, 32'hCAFE_F00D);
    check("post_rst_wr_cnt", wr_cnt, 32'd0);
    check("post_rst_rd_cnt", rd_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
